// File: rtl/id_stage.sv
// id_stage: decode-and-operand stage for the nyakuo core.
// Decodes the RV32I shift/logic subset, reads operands from a 31x32
// register file and registers the result into a single output slot.
// Optional feature macro: ID_WB_FORWARD_EN (writeback-to-operand bypass).

package nyakuo_pkg;
  typedef enum logic [3:0] {
    SLL, SRL, SRA, XOR, OR, AND,
    SLLI, SRLI, SRAI, XORI, ORI, ANDI
  } instruction;
endpackage

module id_stage
  import nyakuo_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [31:0]       instr_i,
  output logic              valid_o,
  input  logic              ready_i,
  output instruction        inst_o,
  output logic [31:0]       operand_a_o,
  output logic [31:0]       operand_b_o,
  output logic [4:0]        rd_o,
  output logic              illegal_o,
  input  logic              wb_we_i,
  input  logic [4:0]        wb_addr_i,
  input  logic [31:0]       wb_data_i
);

  logic [31:0] rf_q [31:1];
  logic [31:0] rf_d [31:1];

  logic        valid_q, valid_d;
  logic        illegal_q, illegal_d;
  instruction  inst_q, inst_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [4:0]  rd_q, rd_d;

  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [4:0]  rs1, rs2;
  logic        legal;
  instruction  dec_op;
  logic        use_shamt, use_simm;
  logic [31:0] rs1_val, rs2_val;
  logic        accept;

  assign opcode = instr_i[6:0];
  assign f3     = instr_i[14:12];
  assign f7     = instr_i[31:25];
  assign rs1    = instr_i[19:15];
  assign rs2    = instr_i[24:20];

  assign in_ready_o = !valid_q || ready_i;
  assign accept     = in_valid_i && in_ready_o;

  // Decode opcode/funct fields into an operation and operand-B source.
  always_comb begin
    legal     = 1'b0;
    dec_op    = SLL;
    use_shamt = 1'b0;
    use_simm  = 1'b0;
    case (opcode)
      7'b0110011: begin
        case (f3)
          3'b001: begin legal = (f7 == 7'b0000000); dec_op = SLL; end
          3'b101: begin
            if (f7 == 7'b0000000)      begin legal = 1'b1; dec_op = SRL; end
            else if (f7 == 7'b0100000) begin legal = 1'b1; dec_op = SRA; end
          end
          3'b100: begin legal = (f7 == 7'b0000000); dec_op = XOR; end
          3'b110: begin legal = (f7 == 7'b0000000); dec_op = OR;  end
          3'b111: begin legal = (f7 == 7'b0000000); dec_op = AND; end
          default: ;
        endcase
      end
      7'b0010011: begin
        case (f3)
          3'b001: begin legal = (f7 == 7'b0000000); dec_op = SLLI; use_shamt = 1'b1; end
          3'b101: begin
            use_shamt = 1'b1;
            if (f7 == 7'b0000000)      begin legal = 1'b1; dec_op = SRLI; end
            else if (f7 == 7'b0100000) begin legal = 1'b1; dec_op = SRAI; end
          end
          3'b100: begin legal = 1'b1; dec_op = XORI; use_simm = 1'b1; end
          3'b110: begin legal = 1'b1; dec_op = ORI;  use_simm = 1'b1; end
          3'b111: begin legal = 1'b1; dec_op = ANDI; use_simm = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Register file read ports; x0 is hardwired to zero.
  always_comb begin
    rs1_val = (rs1 == 5'd0) ? '0 : rf_q[rs1];
    rs2_val = (rs2 == 5'd0) ? '0 : rf_q[rs2];
`ifdef ID_WB_FORWARD_EN
    if (wb_we_i && (wb_addr_i == rs1) && (rs1 != 5'd0)) rs1_val = wb_data_i;
    if (wb_we_i && (wb_addr_i == rs2) && (rs2 != 5'd0)) rs2_val = wb_data_i;
`endif
  end

  // Register file write port; writes to x0 are dropped.
  always_comb begin
    rf_d = rf_q;
    if (wb_we_i && (wb_addr_i != 5'd0)) rf_d[wb_addr_i] = wb_data_i;
  end

  // Output slot: load on legal accept, drain on consume, hold otherwise.
  always_comb begin
    valid_d   = valid_q;
    inst_d    = inst_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    rd_d      = rd_q;
    illegal_d = accept && !legal;
    if (valid_q && ready_i) valid_d = 1'b0;
    if (accept && legal) begin
      valid_d = 1'b1;
      inst_d  = dec_op;
      opa_d   = rs1_val;
      rd_d    = instr_i[11:7];
      if (use_shamt)     opb_d = {27'd0, instr_i[24:20]};
      else if (use_simm) opb_d = {{20{instr_i[31]}}, instr_i[31:20]};
      else               opb_d = rs2_val;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      inst_q    <= SLL;
      opa_q     <= '0;
      opb_q     <= '0;
      rd_q      <= '0;
      for (int unsigned i = 1; i < 32; i++) rf_q[i] <= '0;
    end else begin
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      inst_q    <= inst_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      rd_q      <= rd_d;
      rf_q      <= rf_d;
    end
  end

  assign valid_o     = valid_q;
  assign illegal_o   = illegal_q;
  assign inst_o      = inst_q;
  assign operand_a_o = opa_q;
  assign operand_b_o = opb_q;
  assign rd_o        = rd_q;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: a driver feeds random and directed words
// through a table-driven reference decoder; a monitor checks the slot.
module tb_id_stage;
  import nyakuo_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        in_valid_i, in_ready_o, valid_o, ready_i, illegal_o, wb_we_i;
  logic [31:0] instr_i, operand_a_o, operand_b_o, wb_data_i;
  logic [4:0]  rd_o, wb_addr_i;
  instruction  inst_o;

  id_stage dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .instr_i(instr_i), .valid_o(valid_o), .ready_i(ready_i), .inst_o(inst_o),
    .operand_a_o(operand_a_o), .operand_b_o(operand_b_o), .rd_o(rd_o),
    .illegal_o(illegal_o), .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i)
  );

  always #5 clk_i = ~clk_i;

  // Operand-B source kinds: register, zero-extended shamt, sign-extended imm.
  typedef struct { logic [6:0] opc; logic [2:0] f3; logic [6:0] f7; bit f7_any; instruction op; int kind; } ent_t;
  typedef struct { bit legal; instruction op; logic [31:0] a; logic [31:0] b; logic [4:0] rd; } exp_t;

  ent_t        tbl [12];
  exp_t        sb [$];
  logic [31:0] m_rf [32];
  bit          m_valid;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit ref_decode(input logic [31:0] w, output instruction op, output int kind);
    op = SLL; kind = 0;
    foreach (tbl[i])
      if (w[6:0] == tbl[i].opc && w[14:12] == tbl[i].f3 && (tbl[i].f7_any || w[31:25] == tbl[i].f7)) begin
        op = tbl[i].op; kind = tbl[i].kind;
        return 1'b1;
      end
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a, input bit we, input logic [4:0] wa, input logic [31:0] wd);
`ifdef ID_WB_FORWARD_EN
    if (we && wa == a && a != 0) return wd;
`endif
    return (a == 0) ? 32'd0 : m_rf[a];
  endfunction

  // One cycle of stimulus: drive inputs, advance the model, queue expectations.
  task automatic step(input bit v, input logic [31:0] w, input bit rdy, input bit we,
                      input logic [4:0] wa, input logic [31:0] wd);
    exp_t e; instruction op; int kind; bit exp_rdy;
    in_valid_i = v; instr_i = w; ready_i = rdy; wb_we_i = we; wb_addr_i = wa; wb_data_i = wd;
    exp_rdy = !m_valid || rdy;
    e.legal = 1'b0;
    if (v && exp_rdy) begin
      e.legal = ref_decode(w, op, kind);
      e.op = op;
      e.a  = ref_read(w[19:15], we, wa, wd);
      case (kind)
        0:       e.b = ref_read(w[24:20], we, wa, wd);
        1:       e.b = {27'd0, w[24:20]};
        default: e.b = {{20{w[31]}}, w[31:20]};
      endcase
      e.rd = w[11:7];
      sb.push_back(e);
    end
    if (v && exp_rdy && e.legal) m_valid = 1'b1;
    else if (rdy)                m_valid = 1'b0;
    if (we && wa != 0) m_rf[wa] = wd;
    #1;
    chk("in_ready", {31'd0, in_ready_o}, {31'd0, exp_rdy});
    @(posedge clk_i); #2;
  endtask

  function automatic logic [31:0] rand_word();
    ent_t e; logic [31:0] w;
    e = tbl[$urandom_range(0, 11)];
    w = $urandom;
    w[6:0] = e.opc; w[14:12] = e.f3;
    if (!e.f7_any) w[31:25] = e.f7;
    case ($urandom_range(0, 9))
      0: w[31:25] = 7'($urandom);
      1: w[6:0]   = 7'($urandom);
      default: ;
    endcase
    return w;
  endfunction

  task automatic rand_phase(input int n);
    for (int i = 0; i < n; i++)
      step($urandom_range(0, 9) < 7, rand_word(), $urandom_range(0, 9) < 7,
           $urandom_range(0, 1) == 1, 5'($urandom), $urandom);
  endtask

  task automatic model_reset();
    sb.delete();
    m_valid = 1'b0;
    foreach (m_rf[i]) m_rf[i] = '0;
  endtask

  // Monitor: every presented slot or illegal pulse is matched to the queue front.
  always @(negedge clk_i) begin
    if (illegal_o === 1'b1 || valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb_empty: valid_o=%b illegal_o=%b with nothing expected", valid_o, illegal_o);
      end else if (illegal_o === 1'b1) begin
        chk("illegal_kind", {31'd0, sb[0].legal}, 32'd0);
        void'(sb.pop_front());
      end else begin
        chk("legal_kind", {31'd0, sb[0].legal}, 32'd1);
        chk("inst",  {28'd0, inst_o}, {28'd0, sb[0].op});
        chk("opa",   operand_a_o, sb[0].a);
        chk("opb",   operand_b_o, sb[0].b);
        chk("rd",    {27'd0, rd_o}, {27'd0, sb[0].rd});
        if (ready_i) void'(sb.pop_front());
      end
    end
  end

  initial begin
    tbl[0]  = '{7'h33, 3'd1, 7'h00, 1'b0, SLL,  0};
    tbl[1]  = '{7'h33, 3'd5, 7'h00, 1'b0, SRL,  0};
    tbl[2]  = '{7'h33, 3'd5, 7'h20, 1'b0, SRA,  0};
    tbl[3]  = '{7'h33, 3'd4, 7'h00, 1'b0, XOR,  0};
    tbl[4]  = '{7'h33, 3'd6, 7'h00, 1'b0, OR,   0};
    tbl[5]  = '{7'h33, 3'd7, 7'h00, 1'b0, AND,  0};
    tbl[6]  = '{7'h13, 3'd1, 7'h00, 1'b0, SLLI, 1};
    tbl[7]  = '{7'h13, 3'd5, 7'h00, 1'b0, SRLI, 1};
    tbl[8]  = '{7'h13, 3'd5, 7'h20, 1'b0, SRAI, 1};
    tbl[9]  = '{7'h13, 3'd4, 7'h00, 1'b1, XORI, 2};
    tbl[10] = '{7'h13, 3'd6, 7'h00, 1'b1, ORI,  2};
    tbl[11] = '{7'h13, 3'd7, 7'h00, 1'b1, ANDI, 2};

    rst_ni = 1'b0; in_valid_i = 0; instr_i = '0; ready_i = 0; wb_we_i = 0; wb_addr_i = '0; wb_data_i = '0;
    model_reset();
    #1;
    chk("rst_valid",    {31'd0, valid_o}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
    chk("rst_inst",     {28'd0, inst_o}, {28'd0, SLL});
    @(posedge clk_i); #2; rst_ni = 1'b1;
    @(posedge clk_i); #2;

    rand_phase(300);

    // Reset with the slot full: outputs return to reset values at once.
    step(0, 32'd0, 1, 0, 0, 0);
    step(1, 32'h00209233, 0, 0, 0, 0);
    chk("pre_rst_valid", {31'd0, valid_o}, 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("rst2_valid",   {31'd0, valid_o}, 32'd0);
    chk("rst2_illegal", {31'd0, illegal_o}, 32'd0);
    chk("rst2_inst",    {28'd0, inst_o}, {28'd0, SLL});
    chk("rst2_opa",     operand_a_o, 32'd0);
    chk("rst2_opb",     operand_b_o, 32'd0);
    chk("rst2_rd",      {27'd0, rd_o}, 32'd0);
    chk("rst2_in_ready",{31'd0, in_ready_o}, 32'd1);
    model_reset();
    in_valid_i = 0; ready_i = 0; wb_we_i = 0;
    @(posedge clk_i); #2; rst_ni = 1'b1;
    @(posedge clk_i); #2;
    for (int i = 0; i < 3; i++) step(0, 32'd0, 0, 0, 0, 0);
    chk("post_rst_valid", {31'd0, valid_o}, 32'd0);

    // Writeback to x1 in the accept cycle (x1 is 0 after reset).
    step(1, 32'h0000C193, 1, 1, 5'd1, 32'h12345678);
`ifdef ID_WB_FORWARD_EN
    chk("wb_fwd_opa", operand_a_o, 32'h12345678);
`else
    chk("wb_fwd_opa", operand_a_o, 32'h00000000);
`endif
    step(1, 32'h0000C193, 1, 0, 0, 0);
    chk("wb_next_opa", operand_a_o, 32'h12345678);
    step(1, 32'h00004193, 1, 1, 5'd0, 32'hDEADBEEF);
    chk("x0_fwd_opa", operand_a_o, 32'd0);
    step(1, 32'h00004193, 1, 0, 0, 0);
    chk("x0_read_opa", operand_a_o, 32'd0);

    // XORI sign extension.
    step(0, 32'd0, 1, 1, 5'd1, 32'h000000F0);
    step(1, 32'hFFF0C193, 1, 0, 0, 0);
    chk("xori_inst", {28'd0, inst_o}, {28'd0, XORI});
    chk("xori_opa",  operand_a_o, 32'h000000F0);
    chk("xori_opb",  operand_b_o, 32'hFFFFFFFF);
    chk("xori_rd",   {27'd0, rd_o}, 32'd3);

    // SRAI zero-extended shamt.
    step(0, 32'd0, 1, 1, 5'd2, 32'h80000000);
    step(1, 32'h40715293, 1, 0, 0, 0);
    chk("srai_inst", {28'd0, inst_o}, {28'd0, SRAI});
    chk("srai_opa",  operand_a_o, 32'h80000000);
    chk("srai_opb",  operand_b_o, 32'd7);
    chk("srai_rd",   {27'd0, rd_o}, 32'd5);
    step(0, 32'd0, 1, 0, 0, 0);

    // Backpressure: slot held for 5 cycles, then replaced with no bubble.
    step(1, 32'h00209233, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 32'h0020C333, 0, 0, 0, 0);
      chk("bp_in_ready", {31'd0, in_ready_o}, 32'd0);
      chk("bp_inst", {28'd0, inst_o}, {28'd0, SLL});
      chk("bp_opb",  operand_b_o, 32'h80000000);
      chk("bp_rd",   {27'd0, rd_o}, 32'd4);
    end
    step(1, 32'h0020C333, 1, 0, 0, 0);
    chk("bp_new_inst", {28'd0, inst_o}, {28'd0, XOR});
    chk("bp_new_rd",   {27'd0, rd_o}, 32'd6);

    // Illegal word while the slot drains: valid falls, illegal pulses once.
    step(1, 32'h40001013, 1, 0, 0, 0);
    chk("ill_pulse", {31'd0, illegal_o}, 32'd1);
    chk("ill_valid", {31'd0, valid_o}, 32'd0);
    step(0, 32'd0, 1, 0, 0, 0);
    chk("ill_end",   {31'd0, illegal_o}, 32'd0);
    chk("ill_valid2",{31'd0, valid_o}, 32'd0);

    rand_phase(400);

    for (int i = 0; i < 3; i++) step(0, 32'd0, 1, 0, 0, 0);
    chk("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Decode-and-operand stage feeding the ALU in the nyakuo core. It accepts 32-bit RV32I instruction words over a valid/ready handshake and decodes the shift and logic subset into the package `instruction` enum. It reads source operands from an internal 31x32 register file, which is written by the writeback port. Results are registered into a single output slot, which drives the ALU's `inst_i`, `operand_a_i` and `operand_b_i` one cycle after acceptance.

## Interface
- No parameters; XLEN fixed at 32, 32 architectural registers.
- `clk_i` input 1: clock; all state on rising edge.
- `rst_ni` input 1: asynchronous active-low reset.
- `in_valid_i` input 1: `instr_i` valid.
- `in_ready_o` output 1: stage can accept this cycle.
- `instr_i` input 32: raw instruction word.
- `valid_o` output 1: output slot holds a decoded instruction.
- `ready_i` input 1: downstream (ALU/execute) consumes the slot.
- `inst_o` output `instruction`: decoded operation.
- `operand_a_o` output 32: rs1 value.
- `operand_b_o` output 32: rs2 value, or immediate.
- `rd_o` output 5: destination register.
- `illegal_o` output 1: one-cycle pulse; accepted word was not decodable.
- `wb_we_i` input 1: register file write enable.
- `wb_addr_i` input 5: write address.
- `wb_data_i` input 32: write data.

## Operation
- **Accept:** `in_ready_o = !valid_o || ready_i`. A word is accepted when `in_valid_i && in_ready_o`.
- **Decode, opcode 0110011 (R-type):**
  - Valid ops are SLL (f3=001), SRL (f3=101, f7=0000000), SRA (f3=101, f7=0100000), XOR (f3=100), OR (f3=110) and AND (f3=111).
  - `operand_b` = x[rs2].
  - f7 must be 0000000 except for SRA.
- **Decode, opcode 0010011 (I-type):**
  - SLLI (f3=001, f7=0000000), SRLI/SRAI (f3=101, f7 0000000/0100000). For these, `operand_b` = zero-extended `instr[24:20]`.
  - XORI, ORI and ANDI (f3=100/110/111). For these, `operand_b` = sign-extended `instr[31:20]`.
- **Operands:** `operand_a` = x[rs1] for both formats.
- **Illegal words:** any other opcode/f3/f7 combination is illegal.
  - The word is accepted and dropped; `valid_o` is not set.
  - `illegal_o` pulses high the cycle after acceptance.
- **Register file:**
  - x0 reads 0 and writes to x0 are ignored.
  - x1..x31 are written on the rising edge when `wb_we_i`.
  - A read returns the value at the time of acceptance.
- **Output slot:**
  - On a legal accept, load `inst_o`, operands and `rd_o`, and set `valid_o`.
  - On `valid_o && ready_i` with no new accept, clear `valid_o`.
  - While `valid_o && !ready_i`, all outputs are held stable.
- **Hazards:** RAW hazards against instructions already in or beyond the output slot are not tracked here; the scheduler owns them.

## Timing
- **Reset values:** `valid_o`=0, `illegal_o`=0, `inst_o`=SLL, `operand_a_o`=0, `operand_b_o`=0, `rd_o`=0, all x1..x31=0, `in_ready_o`=1.
- **Latency:** 1 cycle from accept to `valid_o`. Throughput is 1 per cycle when `ready_i` is held high.
- **Simultaneous events:**
  - Consume and accept in the same cycle: the slot is replaced with no bubble.
  - Illegal accept while the slot drains: `valid_o` falls and `illegal_o` rises in the same cycle.
- **Reset mid-operation:** a pending slot is discarded; no `illegal_o` is produced.

## Configuration
- **`ID_WB_FORWARD_EN` defined:**
  - If `wb_we_i` and `wb_addr_i`==rs1/rs2 (nonzero) in the accept cycle, the operand uses `wb_data_i`.
  - Forwarding never applies to rs2 on I-type words.
- **`ID_WB_FORWARD_EN` undefined:** the operand gets the pre-write register value; the new value is visible from the next accept onward.

## Test plan
- **Reset:** assert `rst_ni`=0 mid-stream with a slot full. Required: all outputs immediately at reset values; no `valid_o` after release.
- **XORI sign-extension:** set x1=0x0000_00F0, accept 0xFFF0C193 (XORI x3,x1,-1). Required, next cycle: `inst_o`=XORI, `operand_a_o`=0x0000_00F0, `operand_b_o`=0xFFFF_FFFF, `rd_o`=3.
- **SRAI:** accept 0x40715293 (SRAI x5,x2,7) with x2=0x8000_0000. Required: `inst_o`=SRAI, `operand_b_o`=7, `rd_o`=5.
- **Backpressure:**
  - Hold `ready_i`=0 and accept 0x00209233 (SLL x4,x1,x2). Required: `in_ready_o`=0 and outputs stable for 5 cycles.
  - Then raise `ready_i` while presenting a new word. Required: the new word is accepted in that same cycle.
- **Illegal word:** accept 0x40001013 (SLLI with f7=0100000). Required: `illegal_o` high exactly 1 cycle; `valid_o` stays 0.
- **Writeback in the accept cycle:** `wb_we_i`=1, `wb_addr_i`=1, `wb_data_i`=0x1234_5678, with x1 previously 0. Required `operand_a_o`: 0x1234_5678 with `ID_WB_FORWARD_EN`, 0 without. A write to x0 must read back 0 in both builds.
